// File: rtl/dkong_coin_seq.sv
// dkong_coin_seq: timed coin -> gap -> start pulse sequencer feeding the Donkey Kong core's active-low coin/start inputs.
// Optional build macro DKCOIN_COUNT_EN adds a saturating 16-bit coin_count output for OSD/debug readout.
module dkong_coin_seq #(
    parameter int TICK_DIV = 24576,
    parameter int COIN_MS  = 100,
    parameter int GAP_MS   = 150,
    parameter int START_MS = 100
) (
    input  logic        clk_sys,
    input  logic        RESET,
    input  logic        start1_req,
    input  logic        start2_req,
    input  logic        coin_req,
    output logic        coin_n,
    output logic        start1_n,
    output logic        start2_n,
    output logic        busy
`ifdef DKCOIN_COUNT_EN
    ,
    output logic [15:0] coin_count
`endif
);
    localparam int CG_MS  = COIN_MS > GAP_MS ? COIN_MS : GAP_MS;
    localparam int MAX_MS = CG_MS > START_MS ? CG_MS : START_MS;
    localparam int TW     = $clog2(MAX_MS + 1);
    localparam int PW     = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] COIN_LAST  = TW'(COIN_MS - 1);
    localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_MS - 1);
    localparam logic [TW-1:0] START_LAST = TW'(START_MS - 1);

    typedef enum logic [2:0] {S_IDLE, S_COIN, S_GAP, S_START, S_RELEASE} state_t;
    typedef enum logic [1:0] {P_NONE, P_S1, P_S2} pend_t;

    state_t        state_q, state_d;
    pend_t         pend_q, pend_d;
    logic          coins_q, coins_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [TW-1:0] len_last;
    logic          s1_hist_q, s2_hist_q, coin_hist_q;
    logic          coin_n_q, start1_n_q, start2_n_q, busy_q;
    logic          rise_s1, rise_s2, rise_coin, wrap, expired, timed;
`ifdef DKCOIN_COUNT_EN
    logic [15:0]   count_q, count_d;
`endif

    assign coin_n   = coin_n_q;
    assign start1_n = start1_n_q;
    assign start2_n = start2_n_q;
    assign busy     = busy_q;
`ifdef DKCOIN_COUNT_EN
    assign coin_count = count_q;
`endif

    // Next-state: edge detect, tick timer expiry and sequence transitions
    always_comb begin
        rise_s1   = start1_req & ~s1_hist_q;
        rise_s2   = start2_req & ~s2_hist_q;
        rise_coin = coin_req & ~coin_hist_q;
        wrap      = presc_q == PRESC_LAST;
        len_last  = state_q == S_COIN ? COIN_LAST : state_q == S_GAP ? GAP_LAST : START_LAST;
        expired   = wrap && tick_q == len_last;
        state_d   = state_q;
        pend_d    = pend_q;
        coins_d   = coins_q;
        case (state_q)
            S_IDLE: begin
                if (rise_s2) begin
                    state_d = S_COIN;
                    coins_d = 1'b1;
                    pend_d  = P_S2;
                end else if (rise_s1) begin
                    state_d = S_COIN;
                    coins_d = 1'b0;
                    pend_d  = P_S1;
                end else if (rise_coin) begin
                    state_d = S_COIN;
                    coins_d = 1'b0;
                    pend_d  = P_NONE;
                end
            end
            S_COIN: if (expired) state_d = S_GAP;
            S_GAP: begin
                if (expired) begin
                    if (coins_q) begin
                        coins_d = 1'b0;
                        state_d = S_COIN;
                    end else begin
                        state_d = pend_q != P_NONE ? S_START : S_RELEASE;
                    end
                end
            end
            S_START: begin
                if (expired) begin
                    state_d = S_RELEASE;
                    pend_d  = P_NONE;
                end
            end
            S_RELEASE: if (!(start1_req || start2_req || coin_req)) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Timer restarts on every state entry and idles at zero outside the timed states
        timed   = state_d inside {S_COIN, S_GAP, S_START};
        presc_d = (state_d != state_q || !timed || wrap) ? '0 : presc_q + PW'(1);
        tick_d  = (state_d != state_q || !timed) ? '0 : tick_q + TW'(wrap);
`ifdef DKCOIN_COUNT_EN
        count_d = (state_d == S_COIN && state_q != S_COIN && count_q != 16'hFFFF) ? count_q + 16'd1 : count_q;
`endif
    end

    // State, timer, history and outputs decoded from the next state so they move on the transition edge
    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            pend_q      <= P_NONE;
            coins_q     <= 1'b0;
            presc_q     <= '0;
            tick_q      <= '0;
            s1_hist_q   <= 1'b0;
            s2_hist_q   <= 1'b0;
            coin_hist_q <= 1'b0;
            coin_n_q    <= 1'b1;
            start1_n_q  <= 1'b1;
            start2_n_q  <= 1'b1;
            busy_q      <= 1'b0;
`ifdef DKCOIN_COUNT_EN
            count_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            coins_q     <= coins_d;
            presc_q     <= presc_d;
            tick_q      <= tick_d;
            s1_hist_q   <= start1_req;
            s2_hist_q   <= start2_req;
            coin_hist_q <= coin_req;
            coin_n_q    <= state_d != S_COIN;
            start1_n_q  <= !(state_d == S_START && pend_d == P_S1);
            start2_n_q  <= !(state_d == S_START && pend_d == P_S2);
            busy_q      <= state_d != S_IDLE;
`ifdef DKCOIN_COUNT_EN
            count_q     <= count_d;
`endif
        end
    end
endmodule

// File: tb/tb_dkong_coin_seq.sv
// tb_dkong_coin_seq: table-driven scenarios plus random stimulus checked against a pulse-schedule reference model.
module tb_dkong_coin_seq;
    localparam int TD = 4, CM = 2, GM = 3, SM = 2;
    localparam int COIN_CYC = CM * TD, GAP_CYC = GM * TD, START_CYC = SM * TD;

    logic clk_sys = 0, RESET = 0, start1_req = 0, start2_req = 0, coin_req = 0;
    logic coin_n, start1_n, start2_n, busy;
`ifdef DKCOIN_COUNT_EN
    logic [15:0] coin_count;
`endif
    int n_tests = 0, n_fail = 0;
    bit mon_en = 0;

    dkong_coin_seq #(.TICK_DIV(TD), .COIN_MS(CM), .GAP_MS(GM), .START_MS(SM)) dut (
        .clk_sys(clk_sys), .RESET(RESET),
        .start1_req(start1_req), .start2_req(start2_req), .coin_req(coin_req),
        .coin_n(coin_n), .start1_n(start1_n), .start2_n(start2_n), .busy(busy)
`ifdef DKCOIN_COUNT_EN
        , .coin_count(coin_count)
`endif
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: on a request edge while idle, lay out the whole pulse schedule one entry per clock
    typedef struct packed {logic c; logic s1; logic s2; logic b;} out_t;
    localparam out_t IDLE_O = 4'b1110, HIGH_O = 4'b1111, COIN_O = 4'b0111, S1_O = 4'b1011, S2_O = 4'b1101;
    out_t sched[$];
    out_t exp_o = IDLE_O;
    logic m_p1 = 0, m_p2 = 0, m_pc = 0;
    int   m_who;

    always @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            sched.delete();
            exp_o = IDLE_O;
            m_p1 = 0; m_p2 = 0; m_pc = 0;
        end else begin
            if (!exp_o.b) begin
                m_who = (start2_req && !m_p2) ? 2 : (start1_req && !m_p1) ? 1 : (coin_req && !m_pc) ? 0 : -1;
                if (m_who >= 0) begin
                    for (int i = 0; i < (m_who == 2 ? 2 : 1); i++) begin
                        repeat (COIN_CYC) sched.push_back(COIN_O);
                        repeat (GAP_CYC) sched.push_back(HIGH_O);
                    end
                    if (m_who > 0) repeat (START_CYC) sched.push_back(m_who == 1 ? S1_O : S2_O);
                    sched.push_back(HIGH_O);
                end
            end
            if (sched.size() > 0) exp_o = sched.pop_front();
            else if (exp_o.b && !(start1_req || start2_req || coin_req)) exp_o = IDLE_O;
            m_p1 = start1_req; m_p2 = start2_req; m_pc = coin_req;
        end
    end

    always @(negedge clk_sys) begin
        if (mon_en) begin
            check("mon_coin_n", coin_n, exp_o.c);
            check("mon_start1_n", start1_n, exp_o.s1);
            check("mon_start2_n", start2_n, exp_o.s2);
            check("mon_busy", busy, exp_o.b);
            check("mon_one_low", int'((3 - (int'(coin_n) + int'(start1_n) + int'(start2_n))) <= 1), 1);
        end
    end

    typedef struct {
        logic s1, s2, c;
        int hold, pulses, coin_cyc, s1_cyc, s2_cyc, busy_cyc;
    } vec_t;
    vec_t vecs[6];

    task automatic run_vec(input vec_t v, input int idx);
        int cyc = 0, pulses = 0, cc = 0, c1 = 0, c2 = 0, bc = 0;
        logic last_c = 1;
        @(negedge clk_sys);
        start1_req = v.s1; start2_req = v.s2; coin_req = v.c;
        do begin
            @(negedge clk_sys);
            cyc++;
            if (!coin_n && last_c) pulses++;
            last_c = coin_n;
            cc += int'(!coin_n);
            c1 += int'(!start1_n);
            c2 += int'(!start2_n);
            bc += int'(busy);
            if (cyc == 1) check($sformatf("v%0d_latency", idx), coin_n, 0);
            if (cyc == v.hold) {start1_req, start2_req, coin_req} = 3'b000;
        end while (busy && cyc < 1000);
        {start1_req, start2_req, coin_req} = 3'b000;
        check($sformatf("v%0d_timeout", idx), int'(cyc < 1000), 1);
        check($sformatf("v%0d_pulses", idx), pulses, v.pulses);
        check($sformatf("v%0d_coin_cyc", idx), cc, v.coin_cyc);
        check($sformatf("v%0d_s1_cyc", idx), c1, v.s1_cyc);
        check($sformatf("v%0d_s2_cyc", idx), c2, v.s2_cyc);
        check($sformatf("v%0d_busy_cyc", idx), bc, v.busy_cyc);
        repeat (2) @(negedge clk_sys);
    endtask

    initial begin
        int cyc;
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1,   1, 8,  8, 0, 29};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1,   2, 16, 0, 8, 49};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 1,   1, 8,  0, 0, 21};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 200, 1, 8,  8, 0, 200};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 1,   2, 16, 0, 8, 49};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 50,  1, 8,  0, 0, 50};
        #2 RESET = 1;
        #1;
        check("rst_coin_n", coin_n, 1);
        check("rst_start1_n", start1_n, 1);
        check("rst_start2_n", start2_n, 1);
        check("rst_busy", busy, 0);
        @(negedge clk_sys);
        @(negedge clk_sys);
        RESET = 0;
        mon_en = 1;
        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Asynchronous reset in the middle of a start pulse
        @(negedge clk_sys);
        start1_req = 1;
        @(negedge clk_sys);
        start1_req = 0;
        cyc = 0;
        while (start1_n && cyc < 100) begin
            @(negedge clk_sys);
            cyc++;
        end
        check("reach_start", start1_n, 0);
        @(negedge clk_sys);
        #1 RESET = 1;
        #1;
        check("arst_start1_n", start1_n, 1);
        check("arst_coin_n", coin_n, 1);
        check("arst_busy", busy, 0);
`ifdef DKCOIN_COUNT_EN
        check("arst_count", coin_count, 0);
`endif
        @(negedge clk_sys);
        @(negedge clk_sys);
        RESET = 0;
        run_vec(vecs[2], 6);
`ifdef DKCOIN_COUNT_EN
        check("count_after_coin", coin_count, 1);
`endif

        // Random request traffic, with one short asynchronous reset pulse between edges
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk_sys);
            start1_req = start1_req ? ($urandom_range(3) != 0) : ($urandom_range(80) == 0);
            start2_req = start2_req ? ($urandom_range(3) != 0) : ($urandom_range(80) == 0);
            coin_req   = coin_req   ? ($urandom_range(3) != 0) : ($urandom_range(60) == 0);
            if (i == 2000) begin
                #3 RESET = 1;
                #1 RESET = 0;
            end
        end
        {start1_req, start2_req, coin_req} = 3'b000;
        repeat (100) @(negedge clk_sys);
        mon_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
